// File: rtl/inverse_coretransform.sv
// Inverse H.264 4x4 integer core transform: row pass, column pass, then four output rows.
// Optional macro INVTX_SCALE_EN adds the (x+32)>>>6 final rounding shift before 8-bit saturation.
module inverse_coretransform (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         quantize_ready,
  input  logic [127:0] quantize_data,
  output logic [31:0]  residual_flat,
  output logic         residual_ready,
  output logic         invtx_busy,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic signed [13:0] w [16];
  logic signed [13:0] d [4];
  logic signed [13:0] f [4];
  logic signed [13:0] e0, e1, e2, e3;
  logic [31:0]       out_row;

  function automatic logic signed [14:0] scale(input logic signed [13:0] x);
    logic signed [14:0] y;
    y = 15'(x);
`ifdef INVTX_SCALE_EN
    y = (y + 15'sd32) >>> 6;
`endif
    return y;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [14:0] y);
    if (y > 15'sd127)
      return 8'h7f;
    else if (y < -15'sd128)
      return 8'h80;
    else
      return y[7:0];
  endfunction

  // Operand select: rows in ROW/OUT, columns in COL, all indexed by idx.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (state == COL)
        d[k] = w[{2'(k), idx}];
      else
        d[k] = w[{idx, 2'(k)}];
    end
    e0 = d[0] + d[2];
    e1 = d[0] - d[2];
    e2 = (d[1] >>> 1) - d[3];
    e3 = d[1] + (d[3] >>> 1);
    f[0] = e0 + e3;
    f[1] = e1 + e2;
    f[2] = e1 - e2;
    f[3] = e0 - e3;
    out_row = '0;
    for (int k = 0; k < 4; k++)
      out_row[8*k +: 8] = sat8(scale(d[k]));
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (quantize_ready) begin
          state_nxt = ROW;
          idx_nxt   = 2'd0;
        end
      end
      ROW: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = COL;
      end
      COL: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = OUT;
      end
      OUT: begin
        idx_nxt = idx + 2'd1;
        if (idx == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 2'd0;
      residual_flat  <= '0;
      residual_ready <= 1'b0;
      invtx_busy     <= 1'b0;
      overrun        <= 1'b0;
      for (int k = 0; k < 16; k++)
        w[k] <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      invtx_busy     <= (state != IDLE);
      overrun        <= overrun | (quantize_ready && (state != IDLE));
      residual_ready <= (state == OUT);
      case (state)
        IDLE: begin
          if (quantize_ready)
            for (int k = 0; k < 16; k++)
              w[k] <= 14'(signed'(quantize_data[8*k +: 8]));
        end
        ROW: begin
          for (int k = 0; k < 4; k++)
            w[{idx, 2'(k)}] <= f[k];
        end
        COL: begin
          for (int k = 0; k < 4; k++)
            w[{2'(k), idx}] <= f[k];
        end
        OUT: residual_flat <= out_row;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_coretransform.sv
// Directed + random bench for inverse_coretransform against an integer reference model.
module tb_inverse_coretransform;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         quantize_ready = 1'b0;
  logic [127:0] quantize_data = '0;
  logic [31:0]  residual_flat;
  logic         residual_ready;
  logic         invtx_busy;
  logic         overrun;

  int errors = 0;
  int checks = 0;
  logic ov_exp = 1'b0;

  inverse_coretransform dut (
    .clk(clk),
    .rst_n(rst_n),
    .quantize_ready(quantize_ready),
    .quantize_data(quantize_data),
    .residual_flat(residual_flat),
    .residual_ready(residual_ready),
    .invtx_busy(invtx_busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void kern(input int d0, input int d1, input int d2, input int d3,
                               output int f0, output int f1, output int f2, output int f3);
    int e0, e1, e2, e3;
    e0 = d0 + d2;
    e1 = d0 - d2;
    e2 = (d1 >>> 1) - d3;
    e3 = d1 + (d3 >>> 1);
    f0 = e0 + e3;
    f1 = e1 + e2;
    f2 = e1 - e2;
    f3 = e0 - e3;
  endfunction

  // Returns the four expected output rows packed, row r at [32r+31:32r].
  function automatic logic [127:0] model(input logic [127:0] q);
    int m [4][4];
    int x;
    logic [7:0] b;
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        b = q[8*(4*r+c) +: 8];
        m[r][c] = int'($signed(b));
      end
    for (int r = 0; r < 4; r++)
      kern(m[r][0], m[r][1], m[r][2], m[r][3], m[r][0], m[r][1], m[r][2], m[r][3]);
    for (int c = 0; c < 4; c++)
      kern(m[0][c], m[1][c], m[2][c], m[3][c], m[0][c], m[1][c], m[2][c], m[3][c]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        x = m[r][c];
`ifdef INVTX_SCALE_EN
        x = (x + 32) >>> 6;
`endif
        if (x > 127) x = 127;
        if (x < -128) x = -128;
        res[32*r + 8*c +: 8] = x[7:0];
      end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [127:0] data);
    @(negedge clk);
    quantize_data  = data;
    quantize_ready = 1'b1;
    @(posedge clk);
    #1 quantize_ready = 1'b0;
  endtask

  // Called one step after capture edge T; walks edges T+1..T+13.
  task automatic run_block(input logic [127:0] data, input int inj, input bit chain,
                           input logic [127:0] nxt, input bit use_lit, input logic [31:0] lit);
    logic [127:0] exp;
    logic [31:0]  row_exp;
    exp = model(data);
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == inj) begin
        quantize_data  = {$urandom, $urandom, $urandom, $urandom};
        quantize_ready = 1'b1;
      end
      if (n == 13 && chain) begin
        quantize_data  = nxt;
        quantize_ready = 1'b1;
      end
      @(posedge clk);
      #1 quantize_ready = 1'b0;
      if (n == inj) ov_exp = 1'b1;
      check("busy", 32'(invtx_busy), 32'(n <= 12));
      check("overrun", 32'(overrun), 32'(ov_exp));
      if (n >= 9 && n <= 12) begin
        row_exp = use_lit ? lit : exp[32*(n-9) +: 32];
        check("ready_hi", 32'(residual_ready), 32'd1);
        check("row", residual_flat, row_exp);
      end else begin
        check("ready_lo", 32'(residual_ready), 32'd0);
      end
    end
  endtask

  initial begin
    logic [127:0] a, b, c;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_flat", residual_flat, 32'd0);
    check("rst_ready", 32'(residual_ready), 32'd0);
    check("rst_busy", 32'(invtx_busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // All-zero block
    start('0);
    run_block('0, 0, 1'b0, '0, 1'b1, 32'h0000_0000);

    // DC only
    a = '0;
    a[7:0] = 8'd64;
    start(a);
`ifdef INVTX_SCALE_EN
    run_block(a, 0, 1'b0, '0, 1'b1, 32'h0101_0101);
`else
    run_block(a, 0, 1'b0, '0, 1'b1, 32'h4040_4040);
`endif

    // Saturation and rounding
    a = '0;
    a[15:0] = 16'h7f7f;
    start(a);
`ifdef INVTX_SCALE_EN
    run_block(a, 0, 1'b0, '0, 1'b1, 32'h0001_0304);
`else
    run_block(a, 0, 1'b0, '0, 1'b1, 32'h0040_7f7f);
`endif

    // Extreme negative corner and random blocks, chained back-to-back at T+13
    a = {16{8'h80}};
    b = {$urandom, $urandom, $urandom, $urandom};
    start(a);
    run_block(a, 0, 1'b1, b, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      c = {$urandom, $urandom, $urandom, $urandom};
      run_block(b, 0, 1'b1, c, 1'b0, 32'd0);
      b = c;
    end
    run_block(b, 0, 1'b0, '0, 1'b0, 32'd0);

    // Overrun: strobe at T+5 ignored, third strobe at T+13 accepted
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    start(a);
    run_block(a, 5, 1'b1, b, 1'b0, 32'd0);
    run_block(b, 0, 1'b0, '0, 1'b0, 32'd0);

    // Reset mid-block
    a = {$urandom, $urandom, $urandom, $urandom};
    start(a);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    ov_exp = 1'b0;
    check("midrst_flat", residual_flat, 32'd0);
    check("midrst_ready", 32'(residual_ready), 32'd0);
    check("midrst_busy", 32'(invtx_busy), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(residual_ready), 32'd0);
      check("post_rst_busy", 32'(invtx_busy), 32'd0);
    end
    b = {$urandom, $urandom, $urandom, $urandom};
    start(b);
    run_block(b, 0, 1'b0, '0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
